pipeline_ctrl: RTL and testbench

//  Hazard/sequencing controller for the 5-stage Y86-64 pipeline. Drives stall/bubble for the
//  F, D, E, M, W pipeline registers (load-use, ret, mispredict, exception) and the CC-write

---
 rtl/pipeline_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Y86-64 pipeline hazard controller: stage stall/bubble, CC enable,
// run-status FSM and RUN-time perf counters.
module pipeline_ctrl #(
    parameter int RET_BUBBLES = 3,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       d_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       e_icode,
    input  logic [3:0]       e_dstM,
    input  logic             e_cnd,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       w_stat,
    output logic             f_stall,
    output logic             d_stall,
    output logic             d_bubble,
    output logic             e_bubble,
    output logic             m_bubble,
    output logic             w_stall,
    output logic             set_cc,
    output logic [1:0]       run_state,
    output logic             halt,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    localparam logic [2:0] ST_AOK = 3'd1;
    localparam logic [2:0] ST_HLT = 3'd2;
    localparam logic [2:0] ST_ADR = 3'd3;
    localparam logic [2:0] ST_INS = 3'd4;

    localparam int RC_W = $clog2(RET_BUBBLES + 1);
    localparam logic [RC_W-1:0] RET_LOAD = RC_W'(RET_BUBBLES - 1);

    logic [1:0]      state;
    logic [1:0]      state_nx;
    logic [RC_W-1:0] ret_cnt;

    logic load_use;
    logic mispred;
    logic ret_new;
    logic ret_busy;
    logic stat_ok;

    assign run_state = state;

    always_comb begin
        load_use = ((e_icode == I_MRMOVQ) || (e_icode == I_POPQ)) &&
                   (e_dstM != R_NONE) &&
                   ((e_dstM == d_srcA) || (e_dstM == d_srcB));
        mispred  = (e_icode == I_JXX) && !e_cnd;
        ret_new  = (d_icode == I_RET) && !load_use && !mispred;
        ret_busy = ret_new || (ret_cnt != '0);
        stat_ok  = (m_stat == ST_AOK) && (w_stat == ST_AOK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = S_RUN;
            end
            S_RUN: begin
                if (w_stat == ST_HLT) begin
                    state_nx = S_HALT;
                end else if ((w_stat == ST_ADR) || (w_stat == ST_INS)) begin
                    state_nx = S_FAULT;
                end
            end
            default: state_nx = state;
        endcase
    end

    // Outside RUN the pipe is frozen: F/D/W held, nothing injected.
    always_comb begin
        f_stall  = 1'b1;
        d_stall  = 1'b1;
        d_bubble = 1'b0;
        e_bubble = 1'b0;
        m_bubble = 1'b0;
        w_stall  = 1'b1;
        set_cc   = 1'b0;
        halt     = (state == S_HALT) || (state == S_FAULT);
        unique case (state)
            S_RUN: begin
                f_stall  = load_use || ret_busy;
                d_stall  = load_use;
                d_bubble = mispred || (ret_busy && !load_use);
                e_bubble = mispred || load_use;
                m_bubble = !stat_ok;
                w_stall  = (w_stat != ST_AOK);
                set_cc   = (e_icode == I_OPQ) && stat_ok;
            end
            default: ;
        endcase
    end

    // A squashed wrong-path ret must not leave a pending bubble count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_cnt <= '0;
        end else if (state == S_RUN) begin
            if (mispred) begin
                ret_cnt <= '0;
            end else if (ret_new) begin
                ret_cnt <= RET_LOAD;
            end else if (ret_cnt != '0) begin
                ret_cnt <= ret_cnt - RC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
        end else if (state == S_RUN) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (f_stall) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: expected control vectors are
// queued as stimulus is driven and popped at the following negedge.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  d_icode, d_srcA, d_srcB, e_icode, e_dstM;
    logic        e_cnd;
    logic [2:0]  m_stat, w_stat;
    logic        f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, set_cc;
    logic [1:0]  run_state;
    logic        halt;
    logic [31:0] cycle_cnt, stall_cnt;

    int checks = 0;
    int errors = 0;

    // {f_stall,d_stall,d_bubble,e_bubble,m_bubble,w_stall,set_cc}
    logic [6:0] ctl;
    logic [6:0] exp_q[$];
    logic [6:0] got, e;

    localparam logic [6:0] FROZEN = 7'b1100010;
    localparam logic [6:0] CLEAR  = 7'b0000000;
    localparam logic [6:0] RETV   = 7'b1010000;

    assign ctl = {f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, set_cc};

    always #5 clk = ~clk;

    pipeline_ctrl #(.RET_BUBBLES(3), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .d_icode(d_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .e_icode(e_icode), .e_dstM(e_dstM), .e_cnd(e_cnd),
        .m_stat(m_stat), .w_stat(w_stat),
        .f_stall(f_stall), .d_stall(d_stall), .d_bubble(d_bubble),
        .e_bubble(e_bubble), .m_bubble(m_bubble), .w_stall(w_stall),
        .set_cc(set_cc), .run_state(run_state), .halt(halt),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
    );

    task automatic drive(input logic [3:0] di, input logic [3:0] sa,
                         input logic [3:0] sb, input logic [3:0] ei,
                         input logic [3:0] em, input logic ec,
                         input logic [2:0] ms, input logic [2:0] ws);
        d_icode = di; d_srcA = sa; d_srcB = sb;
        e_icode = ei; e_dstM = em; e_cnd = ec;
        m_stat = ms; w_stat = ws;
    endtask

    task automatic idle_in();
        drive(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 3'd1, 3'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        idle_in();
        #2;
        checks++;
        if (run_state !== 2'd0 || halt !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got %0d/%b exp 0/0", run_state, halt);
        end
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(FROZEN);
        @(negedge clk);
        got = ctl; e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL idle_ctl got %b exp %b", got, e);
        end
        checks++;
        if (cycle_cnt !== 0 || stall_cnt !== 0 || run_state !== 2'd0) begin
            errors++;
            $display("FAIL idle_cnt got %0d/%0d st %0d exp 0/0 st 0",
                     cycle_cnt, stall_cnt, run_state);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        pulse_start();
        checks++;
        if (run_state !== 2'd1) begin
            errors++;
            $display("FAIL start_run got %0d exp 1", run_state);
        end
        drive(4'h1, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 3'd1, 3'd1);
        exp_q.push_back(7'b1101000);
        @(negedge clk);
        got = ctl; e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL load_use got %b exp %b", got, e);
        end
        @(posedge clk); #1;
        idle_in();
        exp_q.push_back(CLEAR);
        @(negedge clk);
        got = ctl; e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL load_use_after got %b exp %b", got, e);
        end
        checks++;
        if (stall_cnt !== 1 || cycle_cnt !== 1) begin
            errors++;
            $display("FAIL lu_cnt got %0d/%0d exp 1/1", stall_cnt, cycle_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ret();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drive(4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 3'd1, 3'd1);
            else idle_in();
            exp_q.push_back(i < 3 ? RETV : CLEAR);
            @(negedge clk);
            got = ctl; e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL ret_c%0d got %b exp %b", i, got, e);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (stall_cnt !== 4) begin
            errors++;
            $display("FAIL ret_stall_cnt got %0d exp 4", stall_cnt);
        end
    endtask

    task automatic test_mispred();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) drive(4'h9, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 3'd1, 3'd1);
            else idle_in();
            exp_q.push_back(i == 0 ? 7'b0011000 : CLEAR);
            @(negedge clk);
            got = ctl; e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL mispred_c%0d got %b exp %b", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            if (i == 0) drive(4'h9, 4'hF, 4'h4, 4'hB, 4'h4, 1'b1, 3'd1, 3'd1);
            else if (i == 1) drive(4'h9, 4'hF, 4'h4, 4'h1, 4'hF, 1'b1, 3'd1, 3'd1);
            else idle_in();
            if (i == 0) exp_q.push_back(7'b1101000);
            else if (i < 4) exp_q.push_back(RETV);
            else exp_q.push_back(CLEAR);
            @(negedge clk);
            got = ctl; e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL lu_ret_c%0d got %b exp %b", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fault();
        int cc;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive(4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b1, 3'd1, 3'd1);
            else if (i == 1) drive(4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b1, 3'd3, 3'd1);
            else drive(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 3'd1, 3'd3);
            if (i == 0) exp_q.push_back(7'b0000001);
            else if (i == 1) exp_q.push_back(7'b0000100);
            else exp_q.push_back(7'b0000110);
            @(negedge clk);
            got = ctl; e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL fault_c%0d got %b exp %b", i, got, e);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (run_state !== 2'd3 || halt !== 1'b1 || ctl !== FROZEN) begin
            errors++;
            $display("FAIL fault_state got %0d/%b/%b exp 3/1/%b",
                     run_state, halt, ctl, FROZEN);
        end
        cc = cycle_cnt;
        idle_in();
        pulse_start();
        @(posedge clk); #1;
        checks++;
        if (run_state !== 2'd3 || cycle_cnt !== cc) begin
            errors++;
            $display("FAIL fault_start got %0d/%0d exp 3/%0d",
                     run_state, cycle_cnt, cc);
        end
    endtask

    task automatic test_halt_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        checks++;
        if (run_state !== 2'd0 || halt !== 1'b0) begin
            errors++;
            $display("FAIL rst_from_fault got %0d/%b exp 0/0", run_state, halt);
        end
        @(posedge clk); #1;
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) drive(4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 3'd1, 3'd1);
            else drive(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 3'd1, 3'd2);
            exp_q.push_back(i == 0 ? RETV : 7'b1010110);
            @(negedge clk);
            got = ctl; e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL halt_c%0d got %b exp %b", i, got, e);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (run_state !== 2'd2 || halt !== 1'b1) begin
            errors++;
            $display("FAIL halt_state got %0d/%b exp 2/1", run_state, halt);
        end
        idle_in();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (run_state !== 2'd0 || halt !== 1'b0 ||
            cycle_cnt !== 0 || stall_cnt !== 0) begin
            errors++;
            $display("FAIL mid_rst got %0d/%b/%0d/%0d exp 0/0/0/0",
                     run_state, halt, cycle_cnt, stall_cnt);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        pulse_start();
        exp_q.push_back(CLEAR);
        @(negedge clk);
        got = ctl; e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL ret_cleared got %b exp %b", got, e);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_ret();
        test_mispred();
        test_back_to_back();
        test_fault();
        test_halt_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
